// File: rtl/game_pkg.sv
// Shared types and constants for the rhythm-game score path.
package game_pkg;

  typedef logic [3:0] bcd_t;

  localparam bcd_t BCD_MAX      = 4'd9;
  localparam int   SCORE_DIGITS = 4;
  localparam int   COMBO_DIGITS = 2;

endpackage

// File: rtl/bcd_digit_add.sv
// Combinational single BCD digit adder with decimal carry correction.
module bcd_digit_add
  import game_pkg::*;
(
  input  bcd_t a,
  input  bcd_t b,
  input  logic carry_in,
  output bcd_t sum,
  output logic carry_out
);

  logic [4:0] raw;
  logic [4:0] adj;

  // Binary add, then fold back into 0-9 by adding 6 when the result passes 9.
  always_comb begin
    raw       = {1'b0, a} + {1'b0, b} + {4'b0000, carry_in};
    adj       = raw + 5'd6;
    carry_out = (raw > 5'd9);
    sum       = carry_out ? adj[3:0] : raw[3:0];
  end

endmodule

// File: rtl/score_bcd_counter.sv
// BCD score and combo keeper: applies one hit/miss per cycle, registers all
// digits, and strobes upd in the cycle the new values appear.
module score_bcd_counter
  import game_pkg::*;
#(
  parameter int BONUS_THRESH = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic hit,
  input  logic miss,
  input  logic [3:0] hit_pts,
  output bcd_t score_d0,
  output bcd_t score_d1,
  output bcd_t score_d2,
  output bcd_t score_d3,
  output bcd_t combo_d0,
  output bcd_t combo_d1,
  output logic saturated,
  output logic upd
);

  function automatic bcd_t clamp_pts(input logic [3:0] pts);
    return (pts > BCD_MAX) ? BCD_MAX : pts;
  endfunction

  function automatic logic [6:0] bcd2_value(input bcd_t hi, input bcd_t lo);
    return ({3'b000, hi} * 7'd10) + {3'b000, lo};
  endfunction

  logic [SCORE_DIGITS-1:0][3:0] score_p1;
  logic [COMBO_DIGITS-1:0][3:0] combo_p1;
  logic                         saturated_p1;
  logic                         vld_p1;

  bcd_t                         pts_base;
  logic [4:0]                   pts_dbl;
  logic [4:0]                   pts_dbl_m10;
  logic                         bonus;
  bcd_t                         pts_lo;
  bcd_t                         pts_hi;

  logic [SCORE_DIGITS-1:0][3:0] score_b;
  logic [SCORE_DIGITS-1:0][3:0] score_sum;
  logic [SCORE_DIGITS:0]        score_c;
  logic [COMBO_DIGITS-1:0][3:0] combo_sum;
  logic [COMBO_DIGITS:0]        combo_c;

  // Points for this hit as two BCD digits (doubled value can reach 18).
  always_comb begin
    pts_base    = clamp_pts(hit_pts);
    pts_dbl     = {pts_base, 1'b0};
    pts_dbl_m10 = pts_dbl - 5'd10;
    bonus       = (bcd2_value(combo_p1[1], combo_p1[0]) >= 7'(BONUS_THRESH));
    pts_lo      = pts_base;
    pts_hi      = 4'd0;
    if (bonus) begin
      if (pts_dbl > 5'd9) begin
        pts_lo = pts_dbl_m10[3:0];
        pts_hi = 4'd1;
      end else begin
        pts_lo = pts_dbl[3:0];
      end
    end
    score_b    = '0;
    score_b[0] = pts_lo;
    score_b[1] = pts_hi;
  end

  assign score_c[0] = 1'b0;
  assign combo_c[0] = 1'b1;

  genvar gi;
  generate
    for (gi = 0; gi < SCORE_DIGITS; gi++) begin : g_score_add
      bcd_digit_add u_add (
        .a         (score_p1[gi]),
        .b         (score_b[gi]),
        .carry_in  (score_c[gi]),
        .sum       (score_sum[gi]),
        .carry_out (score_c[gi+1])
      );
    end
    for (gi = 0; gi < COMBO_DIGITS; gi++) begin : g_combo_inc
      bcd_digit_add u_add (
        .a         (combo_p1[gi]),
        .b         (4'd0),
        .carry_in  (combo_c[gi]),
        .sum       (combo_sum[gi]),
        .carry_out (combo_c[gi+1])
      );
    end
  endgenerate

  // ---- stage p1: event priority (reset/clear > miss > hit), output registers ----
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      score_p1     <= '0;
      combo_p1     <= '0;
      saturated_p1 <= 1'b0;
      vld_p1       <= 1'b0;
    end else if (miss) begin
      combo_p1 <= '0;
      vld_p1   <= 1'b1;
    end else if (hit) begin
      if (saturated_p1 || score_c[SCORE_DIGITS]) begin
        score_p1     <= {SCORE_DIGITS{BCD_MAX}};
        saturated_p1 <= 1'b1;
      end else begin
        score_p1 <= score_sum;
      end
      if (!combo_c[COMBO_DIGITS]) begin
        combo_p1 <= combo_sum;
      end
      vld_p1 <= 1'b1;
    end else begin
      vld_p1 <= 1'b0;
    end
  end

  assign score_d0  = score_p1[0];
  assign score_d1  = score_p1[1];
  assign score_d2  = score_p1[2];
  assign score_d3  = score_p1[3];
  assign combo_d0  = combo_p1[0];
  assign combo_d1  = combo_p1[1];
  assign saturated = saturated_p1;
  assign upd       = vld_p1;

endmodule

// File: tb/tb_score_bcd_counter.sv
// Bench for score_bcd_counter: decimal reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_score_bcd_counter;

  localparam int TH = 10;

  logic       clk;
  logic       rst;
  logic       clear;
  logic       hit;
  logic       miss;
  logic [3:0] hit_pts;
  logic [3:0] score_d0, score_d1, score_d2, score_d3;
  logic [3:0] combo_d0, combo_d1;
  logic       saturated;
  logic       upd;

  int checks = 0;
  int errors = 0;

  // Reference state, kept as plain integers.
  int m_score = 0;
  int m_combo = 0;
  bit m_sat   = 0;
  bit m_upd   = 0;
  bit chk_en  = 0;

  score_bcd_counter #(.BONUS_THRESH(TH)) dut (
    .clk       (clk),
    .rst       (rst),
    .clear     (clear),
    .hit       (hit),
    .miss      (miss),
    .hit_pts   (hit_pts),
    .score_d0  (score_d0),
    .score_d1  (score_d1),
    .score_d2  (score_d2),
    .score_d3  (score_d3),
    .combo_d0  (combo_d0),
    .combo_d1  (combo_d1),
    .saturated (saturated),
    .upd       (upd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int dut_score();
    return int'(score_d3) * 1000 + int'(score_d2) * 100 + int'(score_d1) * 10 + int'(score_d0);
  endfunction

  function automatic int dut_combo();
    return int'(combo_d1) * 10 + int'(combo_d0);
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: scoring rules in decimal arithmetic.
  always @(posedge clk) begin
    int p;
    if (rst || clear) begin
      m_score = 0;
      m_combo = 0;
      m_sat   = 0;
      m_upd   = 0;
      if (rst) chk_en = 1;
    end else if (miss) begin
      m_combo = 0;
      m_upd   = 1;
    end else if (hit) begin
      p = (hit_pts > 9) ? 9 : int'(hit_pts);
      if (m_combo >= TH) p = 2 * p;
      if (m_score + p > 9999) begin
        m_score = 9999;
        m_sat   = 1;
      end else begin
        m_score = m_score + p;
      end
      m_combo = (m_combo >= 99) ? 99 : m_combo + 1;
      m_upd   = 1;
    end else begin
      m_upd = 0;
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("score", dut_score(), m_score);
      check("combo", dut_combo(), m_combo);
      check("saturated", int'(saturated), int'(m_sat));
      check("upd", int'(upd), int'(m_upd));
      check("digits_bcd",
            int'(score_d0 > 9 || score_d1 > 9 || score_d2 > 9 || score_d3 > 9 ||
                 combo_d0 > 9 || combo_d1 > 9), 0);
    end
  end

  task automatic step(input logic r, input logic c, input logic h, input logic m,
                      input logic [3:0] p);
    rst     = r;
    clear   = c;
    hit     = h;
    miss    = m;
    hit_pts = p;
    @(negedge clk);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
  endtask

  task automatic hits(input int n, input logic [3:0] p);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b1, 1'b0, p);
  endtask

  initial begin
    rst = 1'b1; clear = 1'b0; hit = 1'b0; miss = 1'b0; hit_pts = 4'd0;
    @(negedge clk);

    // Reset state.
    step(1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
    check("lit_reset_score", dut_score(), 0);
    check("lit_reset_combo", dut_combo(), 0);
    check("lit_reset_sat", int'(saturated), 0);
    check("lit_reset_upd", int'(upd), 0);

    // Three hits of 5 points, upd one cycle after each.
    for (int i = 1; i <= 3; i++) begin
      step(1'b0, 1'b0, 1'b1, 1'b0, 4'd5);
      check("lit_hit5_upd", int'(upd), 1);
      check("lit_hit5_score", dut_score(), 5 * i);
    end
    check("lit_hit5_combo", dut_combo(), 3);
    idle();
    check("lit_idle_upd", int'(upd), 0);
    check("lit_idle_score", dut_score(), 15);

    // Simultaneous hit and miss with combo 07.
    step(1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
    hits(7, 4'd1);
    check("lit_combo7", dut_combo(), 7);
    step(1'b0, 1'b0, 1'b1, 1'b1, 4'd9);
    check("lit_hitmiss_combo", dut_combo(), 0);
    check("lit_hitmiss_score", dut_score(), 7);
    check("lit_hitmiss_upd", int'(upd), 1);

    // Bonus threshold: first doubled hit arrives with combo 10.
    step(1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
    hits(10, 4'd1);
    check("lit_bonus_pre", dut_score(), 10);
    hits(1, 4'd9);
    check("lit_bonus_post", dut_score(), 28);
    check("lit_bonus_combo", dut_combo(), 11);

    // Reach 9995, then saturate.
    step(1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
    hits(10, 4'd9);
    hits(550, 4'd9);
    check("lit_9990", dut_score(), 9990);
    step(1'b0, 1'b0, 1'b0, 1'b1, 4'd0);
    hits(1, 4'd5);
    check("lit_9995", dut_score(), 9995);
    hits(1, 4'd7);
    check("lit_sat_score", dut_score(), 9999);
    check("lit_sat_flag", int'(saturated), 1);
    hits(1, 4'd3);
    check("lit_sat_hold", dut_score(), 9999);
    check("lit_sat_combo", dut_combo(), 3);
    check("lit_sat_upd", int'(upd), 1);

    // Clamp of hit_pts 15.
    step(1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
    check("lit_clear_sat", int'(saturated), 0);
    hits(1, 4'd15);
    check("lit_clamp", dut_score(), 9);

    // Clear with a simultaneous hit at 0123.
    step(1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
    hits(9, 4'd9);
    hits(1, 4'd6);
    hits(2, 4'd9);
    check("lit_0123", dut_score(), 123);
    step(1'b0, 1'b1, 1'b1, 1'b0, 4'd9);
    check("lit_clrhit_score", dut_score(), 0);
    check("lit_clrhit_combo", dut_combo(), 0);
    check("lit_clrhit_upd", int'(upd), 0);

    // Combo saturates at 99.
    hits(99, 4'd0);
    check("lit_combo99", dut_combo(), 99);
    hits(1, 4'd0);
    check("lit_combo99_hold", dut_combo(), 99);

    // Random traffic with occasional clears/resets.
    for (int i = 0; i < 2000; i++) begin
      step(($urandom % 400) == 0, ($urandom % 60) == 0, ($urandom % 2) == 0,
           ($urandom % 10) == 0, 4'($urandom % 16));
    end

    // Long random run without clears so saturation is reached.
    step(1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
    for (int i = 0; i < 1800; i++) begin
      step(1'b0, 1'b0, ($urandom % 4) != 0, ($urandom % 50) == 0, 4'($urandom % 16));
    end
    check("rand_reached_sat", int'(saturated), 1);

    idle();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
